// File: rtl/fifo_word_serializer_pkg.sv
`default_nettype none
// ============================================================================
// Module  : fifo_ser_pkg
// Brief   : Shared types, default widths and sizing helpers for the serializer.
// Rev     : 1.0 - initial release
// ============================================================================
package fifo_ser_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } ser_state_t;

    localparam int DATA_W_DEFAULT = 64;
    localparam int OUT_W_DEFAULT  = 16;
    localparam int CNT_W_DEFAULT  = 16;

    function automatic int beats(input int data_w, input int out_w);
        return data_w / out_w;
    endfunction

    // Never narrower than one bit, even for illegal configurations
    function automatic int beat_idx_w(input int data_w, input int out_w);
        int n;
        n = beats(data_w, out_w);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_word_serializer_if.sv
`default_nettype none
// ============================================================================
// Module  : fifo_word_serializer_if
// Brief   : FIFO read side plus beat output stream of the word serializer.
// Rev     : 1.0 - initial release
// ============================================================================
interface fifo_word_serializer_if
    import fifo_ser_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEFAULT,
    parameter int OUT_W  = OUT_W_DEFAULT,
    parameter int CNT_W  = CNT_W_DEFAULT
);
    logic              fifo_empty;
    logic [DATA_W-1:0] fifo_data;
    logic              fifo_shift_out;
    logic              out_valid;
    logic              out_ready;
    logic [OUT_W-1:0]  out_data;
    logic              out_last;
    logic              busy;
    logic [CNT_W-1:0]  word_count;

    modport master (
        input  fifo_empty, fifo_data, out_ready,
        output fifo_shift_out, out_valid, out_data, out_last, busy, word_count
    );

    modport slave (
        output fifo_empty, fifo_data, out_ready,
        input  fifo_shift_out, out_valid, out_data, out_last, busy, word_count
    );
endinterface
`default_nettype wire

// File: rtl/fifo_word_serializer.sv
`default_nettype none
// ============================================================================
// Module  : fifo_word_serializer
// Brief   : Pops FIFO words and streams them as OUT_W beats, gap-free.
//           Build option FIFO_SER_MSB_FIRST_EN selects MSB-first beat order.
// Rev     : 1.0 - initial release
// ============================================================================
module fifo_word_serializer
    import fifo_ser_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEFAULT,
    parameter int OUT_W  = OUT_W_DEFAULT,
    parameter int CNT_W  = CNT_W_DEFAULT
) (
    input  wire logic              clk,
    input  wire logic              res_n,
    fifo_word_serializer_if.master bus
);

    localparam int BEATS      = beats(DATA_W, OUT_W);
    localparam int BEAT_IDX_W = beat_idx_w(DATA_W, OUT_W);

    generate
        if (((DATA_W % OUT_W) != 0) || (BEATS < 2)) begin : g_param_check
            $error("fifo_word_serializer: DATA_W must be a multiple of OUT_W with at least 2 beats");
        end
    endgenerate

    ser_state_t              r_state;
    logic [DATA_W-1:0]       r_shift;
    logic [BEAT_IDX_W-1:0]   r_beat_idx;
    logic                    r_last;
    logic [CNT_W-1:0]        r_word_count;

    logic                    w_xfer;
    logic                    w_pop;
    logic [DATA_W-1:0]       w_shift_next;

    assign w_xfer = (r_state == SEND) && bus.out_ready;
    // Reloading on the final-beat transfer is what removes the inter-word bubble
    assign w_pop  = res_n && !bus.fifo_empty &&
                    ((r_state == IDLE) || (r_last && bus.out_ready));

`ifdef FIFO_SER_MSB_FIRST_EN
    assign w_shift_next = r_shift << OUT_W;
    assign bus.out_data = r_shift[DATA_W-1 -: OUT_W];
`else
    assign w_shift_next = r_shift >> OUT_W;
    assign bus.out_data = r_shift[OUT_W-1:0];
`endif

    assign bus.fifo_shift_out = w_pop;
    assign bus.out_valid      = (r_state == SEND);
    assign bus.busy           = (r_state == SEND);
    assign bus.out_last       = r_last;
    assign bus.word_count     = r_word_count;

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            r_state      <= IDLE;
            r_shift      <= '0;
            r_beat_idx   <= '0;
            r_last       <= 1'b0;
            r_word_count <= '0;
        end else begin
            if (w_pop) begin
                r_state    <= SEND;
                r_shift    <= bus.fifo_data;
                r_beat_idx <= '0;
                r_last     <= 1'b0;
            end else if (w_xfer && r_last) begin
                r_state    <= IDLE;
                r_beat_idx <= '0;
                r_last     <= 1'b0;
            end else if (w_xfer) begin
                r_shift    <= w_shift_next;
                r_beat_idx <= r_beat_idx + BEAT_IDX_W'(1);
                r_last     <= (r_beat_idx == BEAT_IDX_W'(BEATS - 2));
            end

            if (w_xfer && r_last) begin
                r_word_count <= r_word_count + CNT_W'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fifo_word_serializer.sv
`default_nettype none
// ============================================================================
// Module  : tb_fifo_word_serializer
// Brief   : Directed vector table, corner sequences and random soak with a
//           FIFO model and beat scoreboard.
// Rev     : 1.0 - initial release
// ============================================================================
module tb_fifo_word_serializer;

    localparam int DW = 64;
    localparam int OW = 16;
    localparam int CW = 16;
    localparam int NB = 4;

    typedef struct {
        logic [DW-1:0]        word;
        logic [NB-1:0][OW-1:0] beat;   // LSB-first order, beat[0] first
    } vec_t;

    logic clk   = 1'b0;
    logic res_n = 1'b0;
    always #5 clk = ~clk;

    fifo_word_serializer_if #(.DATA_W(DW), .OUT_W(OW), .CNT_W(CW)) bus ();

    fifo_word_serializer #(.DATA_W(DW), .OUT_W(OW), .CNT_W(CW)) dut (
        .clk   (clk),
        .res_n (res_n),
        .bus   (bus)
    );

    int            n_tests = 0;
    int            n_fail  = 0;
    logic [DW-1:0] fq[$];
    logic [OW:0]   exp_q[$];
    logic [OW-1:0] got_d[$];
    logic          got_l[$];
    logic [CW-1:0] m_count = '0;
    int            pops = 0;
    logic          prev_stall = 1'b0;
    logic [OW-1:0] prev_d = '0;
    logic          prev_l = 1'b0;
    logic          s_valid, s_last, s_pop;
    logic [OW-1:0] s_data;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [OW-1:0] beat_of(input logic [DW-1:0] w, input int i);
`ifdef FIFO_SER_MSB_FIRST_EN
        return w[DW-1-i*OW -: OW];
`else
        return w[i*OW +: OW];
`endif
    endfunction

    function automatic logic [OW-1:0] tbl_beat(input vec_t v, input int j);
`ifdef FIFO_SER_MSB_FIRST_EN
        return v.beat[NB-1-j];
`else
        return v.beat[j];
`endif
    endfunction

    task automatic refresh();
        bus.fifo_empty = (fq.size() == 0);
        bus.fifo_data  = (fq.size() != 0) ? fq[0] : '0;
    endtask

    task automatic push(input logic [DW-1:0] w);
        fq.push_back(w);
        refresh();
    endtask

    // One clock: sample at negedge, score, then advance the FIFO model
    task automatic tick();
        logic        exp_pop;
        logic [OW:0] e;
        @(negedge clk);
        s_pop   = bus.fifo_shift_out;
        s_valid = bus.out_valid;
        s_data  = bus.out_data;
        s_last  = bus.out_last;
        exp_pop = res_n && (fq.size() != 0) &&
                  ((exp_q.size() == 0) || ((exp_q.size() == 1) && bus.out_ready));
        check("pop", s_pop, exp_pop);
        check("valid", s_valid, exp_q.size() != 0);
        check("busy", bus.busy, exp_q.size() != 0);
        check("word_count", bus.word_count, m_count);
        if (prev_stall) begin
            check("hold_valid", s_valid, 1);
            check("hold_data", s_data, prev_d);
            check("hold_last", s_last, prev_l);
        end
        if (s_valid && bus.out_ready) begin
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("beat_data", s_data, e[OW-1:0]);
                check("beat_last", s_last, e[OW]);
                if (e[OW]) m_count++;
            end
            got_d.push_back(s_data);
            got_l.push_back(s_last);
        end
        if (s_pop && fq.size() != 0) begin
            for (int i = 0; i < NB; i++) exp_q.push_back({(i == NB - 1), beat_of(fq[0], i)});
        end
        if (s_pop) pops++;
        prev_stall = s_valid && !bus.out_ready;
        prev_d     = s_data;
        prev_l     = s_last;
        @(posedge clk);
        if (s_pop && fq.size() != 0) void'(fq.pop_front());
        #1;
        refresh();
    endtask

    task automatic run_until_got(input int n, input int budget);
        int c;
        c = 0;
        while (got_d.size() < n && c < budget) begin
            tick();
            c++;
        end
        check("beats_within_budget", got_d.size(), n);
    endtask

    initial begin
        vec_t          tbl[4];
        int            nv, first_v, last_v, p0;
        logic          found;
        logic [DW-1:0] wa, wb;

        tbl[0] = '{64'h0123_4567_89AB_CDEF, {16'h0123, 16'h4567, 16'h89AB, 16'hCDEF}};
        tbl[1] = '{64'hFFFF_0000_A5A5_1234, {16'hFFFF, 16'h0000, 16'hA5A5, 16'h1234}};
        tbl[2] = '{64'h8000_0000_0000_0001, {16'h8000, 16'h0000, 16'h0000, 16'h0001}};
        tbl[3] = '{64'hDEAD_BEEF_CAFE_F00D, {16'hDEAD, 16'hBEEF, 16'hCAFE, 16'hF00D}};

        bus.out_ready = 1'b0;
        refresh();
        repeat (3) @(posedge clk);
        #1;
        push(64'h1111_2222_3333_4444);
        #1;
        check("rst_valid", bus.out_valid, 0);
        check("rst_data", bus.out_data, 0);
        check("rst_last", bus.out_last, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_count", bus.word_count, 0);
        check("rst_pop", bus.fifo_shift_out, 0);
        fq.delete();
        refresh();
        @(negedge clk);
        res_n = 1'b1;
        @(posedge clk);
        #1;

        // Directed vector table, out_ready held high
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            got_d.delete();
            got_l.delete();
            push(tbl[i].word);
            run_until_got(NB, 20);
            for (int j = 0; j < NB; j++) begin
                if (j < got_d.size()) begin
                    check("tbl_beat", got_d[j], tbl_beat(tbl[i], j));
                    check("tbl_last", got_l[j], j == NB - 1);
                end
            end
            repeat (2) tick();
        end
        check("tbl_word_count", bus.word_count, 4);

        // Back-to-back: three preloaded words, 12 contiguous valid cycles
        nv = 0; first_v = -1; last_v = -1; p0 = pops;
        push(64'h1000_2000_3000_4000);
        push(64'h5000_6000_7000_8000);
        push(64'h9000_A000_B000_C000);
        for (int c = 1; c <= 15; c++) begin
            tick();
            if (s_valid) begin
                nv++;
                if (first_v < 0) first_v = c;
                last_v = c;
            end
        end
        check("b2b_valid_cycles", nv, 12);
        check("b2b_first_valid", first_v, 2);
        check("b2b_last_valid", last_v, 13);
        check("b2b_pops", pops - p0, 3);
        check("b2b_word_count", bus.word_count, 7);

        // Backpressure on beat 2
        got_d.delete();
        got_l.delete();
        wa = 64'hAAAA_BBBB_CCCC_DDDD;
        push(wa);
        push(64'h0F0F_1E1E_2D2D_3C3C);
        run_until_got(2, 20);
        bus.out_ready = 1'b0;
        p0 = pops;
        repeat (5) begin
            tick();
            check("bp_data", s_data, beat_of(wa, 2));
            check("bp_last", s_last, 0);
        end
        check("bp_no_pop", pops - p0, 0);
        bus.out_ready = 1'b1;
        tick();
        check("bp_resume_count", got_d.size(), 3);
        if (got_d.size() >= 3) check("bp_resume_beat", got_d[2], beat_of(wa, 2));
        run_until_got(2 * NB, 30);

        // Final beat accepted with the FIFO empty, then a late word
        got_d.delete();
        got_l.delete();
        repeat (2) tick();
        push(64'h1357_9BDF_2468_ACE0);
        found = 1'b0;
        for (int c = 0; c < 20 && !found; c++) begin
            tick();
            if (s_valid && s_last) found = 1'b1;
        end
        check("eb_final_seen", found, 1);
        check("eb_no_pop", s_pop, 0);
        tick();
        check("eb_idle_valid", s_valid, 0);
        check("eb_idle_busy", bus.busy, 0);
        repeat (2) tick();
        wb = 64'hFEDC_BA98_7654_3210;
        push(wb);
        run_until_got(2 * NB, 20);
        if (got_d.size() >= 2 * NB) begin
            check("eb_late_beat0", got_d[NB], beat_of(wb, 0));
            check("eb_late_last", got_l[2 * NB - 1], 1);
        end

        // Reset after beat 1 of word A with word B queued
        repeat (2) tick();
        got_d.delete();
        got_l.delete();
        wa = 64'hA0A1_A2A3_A4A5_A6A7;
        wb = 64'hB0B1_B2B3_B4B5_B6B7;
        push(wa);
        push(wb);
        run_until_got(2, 20);
        #2;
        res_n = 1'b0;
        #1;
        check("mrst_valid", bus.out_valid, 0);
        check("mrst_data", bus.out_data, 0);
        check("mrst_last", bus.out_last, 0);
        check("mrst_busy", bus.busy, 0);
        check("mrst_count", bus.word_count, 0);
        check("mrst_pop", bus.fifo_shift_out, 0);
        exp_q.delete();
        m_count    = '0;
        prev_stall = 1'b0;
        repeat (2) tick();
        res_n = 1'b1;
        run_until_got(2 + NB, 20);
        if (got_d.size() >= 2 + NB) begin
            check("mrst_b_beat0", got_d[2], beat_of(wb, 0));
            check("mrst_b_last", got_l[2 + NB - 1], 1);
        end
        tick();
        check("mrst_word_count", bus.word_count, 1);

        // Random soak
        for (int c = 0; c < 1000; c++) begin
            if ($urandom_range(0, 2) == 0 && fq.size() < 8) push({$urandom, $urandom});
            bus.out_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        bus.out_ready = 1'b1;
        for (int c = 0; c < 200 && (fq.size() != 0 || exp_q.size() != 0); c++) tick();
        check("soak_drained", (fq.size() == 0) && (exp_q.size() == 0), 1);
        tick();
        check("soak_word_count", bus.word_count, m_count);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fifo_word_serializer.md
# fifo_word_serializer

Downstream drain stage for the 64-bit `fifo`. It pops one word at a time from the FIFO's read side and emits it as a stream of narrower beats on a valid/ready output port. It never pops while holding undelivered beats. It sustains one beat per cycle with no bubble between consecutive words.

## Interface
- `DATA_W`, default 64: FIFO word width. Must be an integer multiple of `OUT_W`.
- `OUT_W`, default 16: output beat width. `BEATS = DATA_W/OUT_W`, which must be at least 2.
- `CNT_W`, default 16: width of the delivered-word counter.
- `clk`, in, 1: single clock; all state updates on its rising edge.
- `res_n`, in, 1: reset, asynchronous, active-low.
- `fifo_empty`, in, 1: the FIFO's `empty`.
- `fifo_data`, in, `DATA_W`: the FIFO's `data_out`. Head word, valid while `fifo_empty`=0 (first-word fall-through).
- `fifo_shift_out`, out, 1: drives the FIFO's `shift_out`. Combinational, one pop per high cycle.
- `out_valid`, out, 1: a beat is presented.
- `out_ready`, in, 1: the consumer accepts the beat.
- `out_data`, out, `OUT_W`: beat payload.
- `out_last`, out, 1: high on the final beat of a word.
- `busy`, out, 1: a word is held (state SEND).
- `word_count`, out, `CNT_W`: number of words fully delivered; wraps modulo 2^`CNT_W`.

## Operation
- **States:**
  - IDLE: no word held.
  - SEND: word held in the shift register; `beat_idx` runs 0..`BEATS`-1.
- **Transfer rule:** a beat transfers on a cycle with `out_valid` && `out_ready`.
- **Pop condition:** `fifo_shift_out` = `res_n` && !`fifo_empty` && (state==IDLE || (`out_last` && `out_ready`)).
- **Pop action:** on a pop edge, `fifo_data` is captured into the shift register, `beat_idx`←0 and state←SEND.
- **IDLE:** `out_valid`=0. A pop moves the block to SEND.
- **SEND, non-final beat transferred:** shift the register by `OUT_W` and increment `beat_idx`.
- **SEND, final beat transferred:**
  - `word_count` increments.
  - If a pop occurs in the same cycle, stay in SEND with the new word, so there is no bubble.
  - Otherwise go to IDLE.
- **SEND outputs:** `out_valid`=1, `out_last` = (`beat_idx`==`BEATS`-1), `busy`=1.
- **Backpressure:** while `out_valid` && !`out_ready`, `out_data`, `out_last` and `beat_idx` hold stable. `out_valid` never drops before the transfer.
- **FIFO empty:** `fifo_shift_out` is never high while `fifo_empty`=1. The FIFO is never over-read.
- **Simultaneous events:** a final-beat transfer together with `fifo_empty`=1 goes to IDLE. A later non-empty FIFO restarts from IDLE.
- **Reset mid-word:** the partially sent word is discarded, not replayed. After reset the FIFO head is the next word sent.

## Timing
- **Reset values:** state IDLE, `out_valid` 0, `out_data` 0, `out_last` 0, `busy` 0, `word_count` 0, `beat_idx` 0, `fifo_shift_out` 0.
- **Latency:** pop on edge N puts beat 0 on `out_data` after edge N, with `out_valid`=1 in cycle N+1.
- **Throughput:** with `out_ready` held high, one beat per cycle. Consecutive words take exactly `BEATS` cycles each.
- **Combinational paths:**
  - `fifo_shift_out` depends combinationally on `out_ready` and `fifo_empty`.
  - `out_*` and `busy` are registered.
  - `word_count` updates on the edge of the final-beat transfer.

## Configuration
- Macro: `FIFO_SER_MSB_FIRST_EN`.
- **Undefined:** beat 0 = `fifo_data[OUT_W-1:0]` (LSB first). The register shifts right.
- **Defined:** beat 0 = `fifo_data[DATA_W-1:DATA_W-OUT_W]` (MSB first). The register shifts left.
- Interface and timing are identical in both builds.

## Structure
- Package `fifo_ser_pkg` holds:
  - the state enum `ser_state_t` (IDLE, SEND);
  - default width constants;
  - the function `beats(DATA_W, OUT_W)` and a `BEAT_IDX_W` = `$clog2(BEATS)` helper.
- Single flat module. The shift register, beat counter and FSM are inline; no sub-module.
- Elaboration check: `DATA_W % OUT_W`==0 and `BEATS`≥2.

## Test plan
- **Reset then one word:** push 64'h0123_4567_89AB_CDEF, `out_ready`=1. Expect beats EF CD? no: 16'hCDEF, 89AB, 4567, 0123, with `out_last` on the 4th. `word_count`=1, then IDLE. With the macro defined, the beat order is reversed.
- **Back-to-back:** preload 3 words, `out_ready`=1. Expect 12 consecutive valid cycles with no gap, exactly 3 `fifo_shift_out` pulses, and `word_count`=3.
- **Backpressure:** hold `out_ready`=0 for 5 cycles on beat 2. `out_data` and `out_last` stay stable, no pop occurs, and beat 2 transfers on the first ready cycle.
- **Empty boundary:** final beat accepted while `fifo_empty`=1. Expect `fifo_shift_out`=0, state IDLE, `out_valid`=0. A word pushed 3 cycles later is emitted correctly.
- **Reset mid-word:** assert `res_n`=0 after beat 1 of word A with word B queued. All outputs go to 0 immediately. After release, word B is emitted and word A is never resumed.
- **Random soak:** 1000 cycles of random FIFO pushes and random `out_ready`. The scoreboard checks beat order, no FIFO over-read, and that `word_count` matches the number of words delivered.
